// File: rtl/fb_pkg.sv
// ============================================================================
// Module      : fb_pkg
// Description : Shared types, defaults and address-width helper for the
//               banked frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } fb_clear_state_t;

    localparam int FB_DEFAULT_CLEAR_VALUE = 0;

    // A single bank still reserves one select bit so the flat address always
    // has a bank field.
    function automatic int fb_addr_w(input int bank_addr_w, input int num_banks);
        int sel_w;
        sel_w = $clog2(num_banks);
        if (sel_w < 1) begin
            sel_w = 1;
        end
        return bank_addr_w + sel_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fb_bank.sv
// ============================================================================
// Module      : fb_bank
// Description : One true dual-port RAM bank with read-old-data behaviour and a
//               two-register read path, plus a write-only clear port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              wren_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              wren_b,
    input  logic              clear_wren,
    input  logic [ADDR_W-1:0] clear_addr,
    input  logic [DATA_W-1:0] clear_data,
    output logic [DATA_W-1:0] q_a,
    output logic [DATA_W-1:0] q_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_a;
    logic [DATA_W-1:0] r_rd_b;

    // Reads sample the array before this edge's writes land (old data); the
    // clear port is only active while user writes are blocked upstream.
    always_ff @(posedge clock) begin
        if (wren_a) begin
            r_mem[address_a] <= data_a;
        end
        if (wren_b) begin
            r_mem[address_b] <= data_b;
        end
        if (clear_wren) begin
            r_mem[clear_addr] <= clear_data;
        end
        r_rd_a <= r_mem[address_a];
        r_rd_b <= r_mem[address_b];
        q_a    <= r_rd_a;
        q_b    <= r_rd_b;
    end

endmodule

`default_nettype wire

// File: rtl/banked_frame_buffer.sv
// ============================================================================
// Module      : banked_frame_buffer
// Description : Two-port banked frame buffer with bank decode, out-of-range
//               flags, write-collision arbitration and a registered output mux.
//               Optional clear engine enabled by defining FB_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banked_frame_buffer
    import fb_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                BANK_ADDR_W = 16,
    parameter int                NUM_BANKS   = 5,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(FB_DEFAULT_CLEAR_VALUE),
    localparam int               ADDR_W      = fb_addr_w(BANK_ADDR_W, NUM_BANKS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              wren_a,
    input  logic              rden_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              wren_b,
    input  logic              rden_b,
    output logic [DATA_W-1:0] q_a,
    output logic              valid_a,
    output logic              oor_a,
    output logic [DATA_W-1:0] q_b,
    output logic              valid_b,
    output logic              oor_b,
    output logic              collision
`ifdef FB_CLEAR_EN
    ,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done
`endif
);

    localparam int SEL_W = ADDR_W - BANK_ADDR_W;

    logic [SEL_W-1:0]       w_sel_a;
    logic [SEL_W-1:0]       w_sel_b;
    logic                   w_oor_a;
    logic                   w_oor_b;
    logic                   w_same_addr;
    logic                   w_wr_a_ok;
    logic                   w_wr_b_ok;
    logic                   w_coll;
    logic                   w_busy;
    logic                   w_clr_we;
    logic [BANK_ADDR_W-1:0] w_clr_addr;

    logic [DATA_W-1:0] w_bank_q_a [NUM_BANKS];
    logic [DATA_W-1:0] w_bank_q_b [NUM_BANKS];
    logic [DATA_W-1:0] w_mux_a;
    logic [DATA_W-1:0] w_mux_b;

    logic             r_v1_a, r_v2_a, r_oor1_a, r_oor2_a;
    logic             r_v1_b, r_v2_b, r_oor1_b, r_oor2_b;
    logic [SEL_W-1:0] r_sel1_a, r_sel2_a, r_sel1_b, r_sel2_b;

    assign w_sel_a     = address_a[ADDR_W-1:BANK_ADDR_W];
    assign w_sel_b     = address_b[ADDR_W-1:BANK_ADDR_W];
    assign w_oor_a     = (int'(w_sel_a) >= NUM_BANKS);
    assign w_oor_b     = (int'(w_sel_b) >= NUM_BANKS);
    assign w_same_addr = (address_a == address_b);

    // Port A wins an identical-address write; port B's write is dropped.
    assign w_coll    = wren_a && wren_b && w_same_addr && !w_busy;
    assign w_wr_a_ok = wren_a && !w_oor_a && !w_busy;
    assign w_wr_b_ok = wren_b && !w_oor_b && !w_busy && !(wren_a && w_same_addr);

`ifdef FB_CLEAR_EN
    fb_clear_state_t        r_state;
    fb_clear_state_t        w_state_nxt;
    logic [BANK_ADDR_W-1:0] r_clr_addr;
    logic [BANK_ADDR_W-1:0] w_clr_addr_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_busy         = 1'b0;
        clear_busy     = 1'b0;
        clear_done     = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr_addr_nxt = '0;
                if (clear_req) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_busy         = 1'b1;
                clear_busy     = 1'b1;
                w_clr_addr_nxt = r_clr_addr + BANK_ADDR_W'(1);
                if (&r_clr_addr) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                clear_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_clr_we   = w_busy && !reset;
    assign w_clr_addr = r_clr_addr;
`else
    assign w_busy     = 1'b0;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic w_we_a;
        logic w_we_b;

        assign w_we_a = w_wr_a_ok && (w_sel_a == SEL_W'(b));
        assign w_we_b = w_wr_b_ok && (w_sel_b == SEL_W'(b));

        fb_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (BANK_ADDR_W)
        ) u_bank (
            .clock      (clock),
            .address_a  (address_a[BANK_ADDR_W-1:0]),
            .data_a     (data_a),
            .wren_a     (w_we_a),
            .address_b  (address_b[BANK_ADDR_W-1:0]),
            .data_b     (data_b),
            .wren_b     (w_we_b),
            .clear_wren (w_clr_we),
            .clear_addr (w_clr_addr),
            .clear_data (CLEAR_VALUE),
            .q_a        (w_bank_q_a[b]),
            .q_b        (w_bank_q_b[b])
        );
    end

    always_comb begin
        w_mux_a = '0;
        w_mux_b = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (r_sel2_a == SEL_W'(b)) begin
                w_mux_a = w_bank_q_a[b];
            end
            if (r_sel2_b == SEL_W'(b)) begin
                w_mux_b = w_bank_q_b[b];
            end
        end
    end

    // Bank select and range flag travel alongside the two RAM read registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_v1_a    <= 1'b0;
            r_v2_a    <= 1'b0;
            r_oor1_a  <= 1'b0;
            r_oor2_a  <= 1'b0;
            r_sel1_a  <= '0;
            r_sel2_a  <= '0;
            r_v1_b    <= 1'b0;
            r_v2_b    <= 1'b0;
            r_oor1_b  <= 1'b0;
            r_oor2_b  <= 1'b0;
            r_sel1_b  <= '0;
            r_sel2_b  <= '0;
            q_a       <= '0;
            valid_a   <= 1'b0;
            oor_a     <= 1'b0;
            q_b       <= '0;
            valid_b   <= 1'b0;
            oor_b     <= 1'b0;
            collision <= 1'b0;
        end else begin
            r_v1_a    <= rden_a;
            r_oor1_a  <= w_oor_a;
            r_sel1_a  <= w_sel_a;
            r_v2_a    <= r_v1_a;
            r_oor2_a  <= r_oor1_a;
            r_sel2_a  <= r_sel1_a;
            r_v1_b    <= rden_b;
            r_oor1_b  <= w_oor_b;
            r_sel1_b  <= w_sel_b;
            r_v2_b    <= r_v1_b;
            r_oor2_b  <= r_oor1_b;
            r_sel2_b  <= r_sel1_b;
            collision <= w_coll;

            valid_a <= r_v2_a;
            oor_a   <= r_v2_a && r_oor2_a;
            if (r_v2_a) begin
                q_a <= r_oor2_a ? '0 : w_mux_a;
            end
            valid_b <= r_v2_b;
            oor_b   <= r_v2_b && r_oor2_b;
            if (r_v2_b) begin
                q_b <= r_oor2_b ? '0 : w_mux_b;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_banked_frame_buffer.sv
// ============================================================================
// Module      : tb_banked_frame_buffer
// Description : Directed self-checking bench with a behavioural reference
//               model; FB_CLEAR_EN adds the clear-engine scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_banked_frame_buffer;

`ifdef FB_CLEAR_EN
    localparam int          BAW = 4;
    localparam logic [7:0]  CV  = 8'h0F;
`else
    localparam int          BAW = 16;
    localparam logic [7:0]  CV  = 8'h00;
`endif
    localparam int NB    = 5;
    localparam int AW    = BAW + 3;
    localparam int DEPTH = 1 << BAW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_a, addr_b;
    logic [7:0]    data_a, data_b;
    logic          wren_a, wren_b, rden_a, rden_b;
    logic [7:0]    q_a, q_b;
    logic          valid_a, valid_b, oor_a, oor_b, collision;
`ifdef FB_CLEAR_EN
    logic          clear_req, clear_busy, clear_done;
`endif

    always #5 clk = ~clk;

    banked_frame_buffer #(
        .DATA_W      (8),
        .BANK_ADDR_W (BAW),
        .NUM_BANKS   (NB),
        .CLEAR_VALUE (CV)
    ) dut (
        .clock     (clk),
        .reset     (rst),
        .address_a (addr_a),
        .data_a    (data_a),
        .wren_a    (wren_a),
        .rden_a    (rden_a),
        .address_b (addr_b),
        .data_b    (data_b),
        .wren_b    (wren_b),
        .rden_b    (rden_b),
        .q_a       (q_a),
        .valid_a   (valid_a),
        .oor_a     (oor_a),
        .q_b       (q_b),
        .valid_b   (valid_b),
        .oor_b     (oor_b),
        .collision (collision)
`ifdef FB_CLEAR_EN
        ,
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic       v;
        logic       oor;
        logic       known;
        logic [7:0] q;
    } rd_t;

    logic [7:0] m_mem [int];
    rd_t  p1_a, p2_a, p1_b, p2_b;
    logic e_v_a = 0, e_oor_a = 0, e_k_a = 1, e_v_b = 0, e_oor_b = 0, e_k_b = 1;
    logic [7:0] e_q_a = 0, e_q_b = 0;
    logic e_coll = 0;
    logic m_busy = 0, m_done = 0;
    int   m_k = 0;

    function automatic rd_t mread(input logic en, input logic [AW-1:0] a);
        rd_t r;
        r.v = en; r.oor = 1'b0; r.known = 1'b1; r.q = 8'h00;
        if ((int'(a) >> BAW) >= NB) r.oor = 1'b1;
        else if (m_mem.exists(int'(a))) r.q = m_mem[int'(a)];
        else r.known = 1'b0;
        return r;
    endfunction

    function automatic logic in_range(input logic [AW-1:0] a);
        return (int'(a) >> BAW) < NB;
    endfunction

    always @(posedge clk) begin : p_model
        rd_t ra, rb;
        ra = mread(rden_a, addr_a);
        rb = mread(rden_b, addr_b);
        if (rst) begin
            p1_a.v = 0; p2_a.v = 0; p1_b.v = 0; p2_b.v = 0;
            e_v_a = 0; e_oor_a = 0; e_q_a = 0; e_k_a = 1;
            e_v_b = 0; e_oor_b = 0; e_q_b = 0; e_k_b = 1;
            e_coll = 0; m_busy = 0; m_done = 0; m_k = 0;
        end else begin
            if (p2_a.v) begin
                e_v_a = 1; e_oor_a = p2_a.oor; e_q_a = p2_a.q; e_k_a = p2_a.known;
            end else begin
                e_v_a = 0; e_oor_a = 0;
            end
            if (p2_b.v) begin
                e_v_b = 1; e_oor_b = p2_b.oor; e_q_b = p2_b.q; e_k_b = p2_b.known;
            end else begin
                e_v_b = 0; e_oor_b = 0;
            end
            p2_a = p1_a; p1_a = ra;
            p2_b = p1_b; p1_b = rb;
            e_coll = wren_a && wren_b && (addr_a == addr_b) && !m_busy;
            if (!m_busy) begin
                if (wren_a && in_range(addr_a)) m_mem[int'(addr_a)] = data_a;
                if (wren_b && in_range(addr_b) && !(wren_a && addr_a == addr_b))
                    m_mem[int'(addr_b)] = data_b;
            end
            if (m_busy) begin
                for (int b = 0; b < NB; b++) m_mem[(b << BAW) | m_k] = CV;
                if (m_k == DEPTH - 1) begin
                    m_busy = 0; m_done = 1;
                end else begin
                    m_k++;
                end
            end else if (m_done) begin
                m_done = 0;
            end
`ifdef FB_CLEAR_EN
            else if (clear_req) begin
                m_busy = 1; m_k = 0;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_a", valid_a, e_v_a);
            chk("oor_a", oor_a, e_oor_a);
            if (e_k_a) chk("q_a", q_a, e_q_a);
            chk("valid_b", valid_b, e_v_b);
            chk("oor_b", oor_b, e_oor_b);
            if (e_k_b) chk("q_b", q_b, e_q_b);
            chk("collision", collision, e_coll);
`ifdef FB_CLEAR_EN
            chk("clear_busy", clear_busy, m_busy);
            chk("clear_done", clear_done, m_done);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] mk(input int bank, input int off);
        int unsigned v;
        v = (bank << BAW) | (off & (DEPTH - 1));
        return v[AW-1:0];
    endfunction

    task automatic wr(input bit port_b, input logic [AW-1:0] a, input logic [7:0] d);
        if (port_b) begin wren_b = 1; addr_b = a; data_b = d; end
        else begin wren_a = 1; addr_a = a; data_a = d; end
        tick();
        wren_a = 0; wren_b = 0;
    endtask

    task automatic rd_chk(input string nm, input bit port_b, input logic [AW-1:0] a,
                          input logic [7:0] eq, input logic eoor);
        if (port_b) begin rden_b = 1; addr_b = a; end
        else begin rden_a = 1; addr_a = a; end
        tick();
        rden_a = 0; rden_b = 0;
        tick();
        tick();
        chk({nm, "_valid"}, port_b ? valid_b : valid_a, 1'b1);
        chk({nm, "_q"}, port_b ? q_b : q_a, eq);
        chk({nm, "_oor"}, port_b ? oor_b : oor_a, eoor);
    endtask

    initial begin
        int busy_cnt;
        rst = 1; addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;
        wren_a = 0; wren_b = 0; rden_a = 0; rden_b = 0;
`ifdef FB_CLEAR_EN
        clear_req = 0;
`endif
        tick(); tick();
        chk_en = 1;
        chk("rst_valid_a", valid_a, 1'b0);
        chk("rst_q_a", q_a, 8'h00);
        chk("rst_q_b", q_b, 8'h00);
        chk("rst_collision", collision, 1'b0);
        rst = 0;
        tick();

        // write A, read back on B
        wr(0, mk(2, 'h10), 8'hA5);
        rd_chk("wr_rd", 1, mk(2, 'h10), 8'hA5, 1'b0);

        // same in-bank address in banks 0 and 4, back-to-back reads
        wr(0, mk(0, 3), 8'h11);
        wr(0, mk(4, 3), 8'h22);
        rden_a = 1; addr_a = mk(0, 3); tick();
        addr_a = mk(4, 3); tick();
        rden_a = 0; tick();
        chk("b2b_first", q_a, 8'h11);
        tick();
        chk("b2b_second", q_a, 8'h22);

        // identical-address collision
        wren_a = 1; wren_b = 1; addr_a = mk(1, 'h100); addr_b = mk(1, 'h100);
        data_a = 8'h33; data_b = 8'h44;
        tick();
        wren_a = 0; wren_b = 0;
        chk("coll_pulse", collision, 1'b1);
        tick();
        chk("coll_clear", collision, 1'b0);
        rd_chk("coll_rd", 1, mk(1, 'h100), 8'h33, 1'b0);

        // different banks, same cycle: both land, no collision
        wren_a = 1; wren_b = 1; addr_a = mk(1, 'h200); addr_b = mk(2, 'h200);
        data_a = 8'h5A; data_b = 8'h6B;
        tick();
        wren_a = 0; wren_b = 0;
        chk("nocoll", collision, 1'b0);
        rd_chk("dual_a", 0, mk(1, 'h200), 8'h5A, 1'b0);
        rd_chk("dual_b", 1, mk(2, 'h200), 8'h6B, 1'b0);

        // read-during-write: both ports see old data
        wr(0, mk(3, 7), 8'h55);
        wren_a = 1; data_a = 8'h66; addr_a = mk(3, 7); rden_a = 1;
        rden_b = 1; addr_b = mk(3, 7);
        tick();
        wren_a = 0; rden_a = 0; rden_b = 0;
        tick(); tick();
        chk("rdw_a_old", q_a, 8'h55);
        chk("rdw_b_old", q_b, 8'h55);
        rd_chk("rdw_new", 0, mk(3, 7), 8'h66, 1'b0);

        // out-of-range bank
        wr(1, mk(1, 0), 8'hC3);
        wr(0, mk(5, 0), 8'h77);
        rd_chk("oor", 0, mk(5, 0), 8'h00, 1'b1);
        rd_chk("oor_untouched", 1, mk(1, 0), 8'hC3, 1'b0);

        // streaming mix checked by the model
        for (int i = 0; i < 8; i++) begin
            wren_a = 1; addr_a = mk(i % 5, i * 3); data_a = 8'(i * 17 + 1);
            rden_b = 1; addr_b = mk((i + 4) % 5, (i - 1) * 3);
            tick();
        end
        wren_a = 0; rden_b = 0;
        tick(); tick(); tick();

        // reset mid-read discards the read
        rden_a = 1; addr_a = mk(2, 'h10); tick();
        rden_a = 0; rst = 1; tick();
        rst = 0;
        chk("rst_midread_v", valid_a, 1'b0);
        tick();
        chk("rst_midread_v2", valid_a, 1'b0);
        tick();

`ifdef FB_CLEAR_EN
        wr(0, mk(3, 5), 8'h99);
        clear_req = 1; tick(); clear_req = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && clear_busy; i++) begin
            wren_a = (i == 5); addr_a = mk(0, 0); data_a = 8'h55;
            rden_b = (i == 3); addr_b = mk(4, 9);
            tick();
            busy_cnt++;
        end
        wren_a = 0; rden_b = 0;
        chk("clear_len", busy_cnt, 16);
        chk("clear_done_pulse", clear_done, 1'b1);
        tick();
        chk("clear_done_drop", clear_done, 1'b0);
        rd_chk("cleared", 0, mk(3, 5), 8'h0F, 1'b0);
        rd_chk("midclr_wr_dropped", 1, mk(0, 0), 8'h0F, 1'b0);

        // reset mid-clear, then a fresh full clear
        wr(0, mk(2, 0), 8'hAB);
        wr(0, mk(2, 15), 8'hAB);
        clear_req = 1; tick(); clear_req = 0;
        tick(); tick();
        rst = 1; tick(); rst = 0;
        chk("rst_clr_busy", clear_busy, 1'b0);
        chk("rst_clr_done", clear_done, 1'b0);
        rd_chk("partial_lo", 0, mk(2, 0), 8'h0F, 1'b0);
        rd_chk("partial_hi", 0, mk(2, 15), 8'hAB, 1'b0);
        clear_req = 1; tick(); clear_req = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && clear_busy; i++) begin
            tick();
            busy_cnt++;
        end
        chk("reclear_len", busy_cnt, 16);
        tick();
        rd_chk("reclear_hi", 1, mk(2, 15), 8'h0F, 1'b0);
`else
        busy_cnt = 0;
        chk("no_clear_cnt", busy_cnt + collision, 0);
`endif

        tick();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
